// File: rtl/draw_arbiter.sv
// Arbitrates the display draw-command port between local strokes (req0), remote strokes (req1)
// and injected full-screen clears, issuing one segment at a time and tracking display busy.
module draw_arbiter #(
    parameter int unsigned COL_W        = 8,
    parameter int unsigned ROW_W        = 9,
    parameter int unsigned COLOR_W      = 3,
    parameter int unsigned SEG_W        = 2 * COL_W + 2 * ROW_W + COLOR_W,
    parameter int unsigned BURST        = 4,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned MAX_COL      = 239,
    parameter int unsigned MAX_ROW      = 319,
    parameter int unsigned CLEAR_COLOR  = 0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req0_valid_in,
    input  logic [SEG_W-1:0] req0_seg_in,
    output logic             req0_ready_out,
    input  logic             req1_valid_in,
    input  logic [SEG_W-1:0] req1_seg_in,
    output logic             req1_ready_out,
    input  logic             clear_req_in,
    input  logic             disp_busy_in,
    output logic             disp_valid_out,
    output logic [SEG_W-1:0] disp_seg_out,
    output logic [1:0]       grant_out
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    localparam logic [1:0] GrNone  = 2'b00;
    localparam logic [1:0] GrReq0  = 2'b01;
    localparam logic [1:0] GrReq1  = 2'b10;
    localparam logic [1:0] GrClear = 2'b11;

    localparam int unsigned BurstW = $clog2(BURST + 1);
    localparam int unsigned TmoW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [BurstW-1:0] BurstMax = BurstW'(BURST);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(BUSY_TIMEOUT - 1);

    localparam logic [SEG_W-1:0] ClearSeg = {COL_W'(0), COL_W'(MAX_COL), ROW_W'(0),
                                             ROW_W'(MAX_ROW), COLOR_W'(CLEAR_COLOR)};

    logic [1:0]        state_q, state_d;
    logic              clear_pending_q, clear_pending_d;
    logic              rr_q, rr_d;
    logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              disp_valid_q, disp_valid_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        sel;
    logic [BurstW-1:0] burst_inc;

    // rr_q holds the last requester granted; it is the "last owner" for the burst rule.
    always_comb begin
        sel = GrNone;
        if (state_q == StIdle) begin
            if (clear_pending_q) begin
                sel = GrClear;
            end else if (req0_valid_in && req1_valid_in) begin
                if (burst_cnt_q < BurstMax) begin
                    sel = rr_q ? GrReq1 : GrReq0;
                end else begin
                    sel = rr_q ? GrReq0 : GrReq1;
                end
            end else if (req0_valid_in) begin
                sel = GrReq0;
            end else if (req1_valid_in) begin
                sel = GrReq1;
            end
        end
    end

    // Saturating so a sole requester can run indefinitely without wrapping the count.
    assign burst_inc = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        burst_cnt_d     = burst_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        seg_d           = seg_q;
        grant_d         = grant_q;
        disp_valid_d    = 1'b0;
        ready0_d        = 1'b0;
        ready1_d        = 1'b0;
        clear_pending_d = clear_req_in | (clear_pending_q & (sel != GrClear));

        case (state_q)
            StIdle: begin
                if (sel != GrNone) begin
                    state_d      = StIssue;
                    disp_valid_d = 1'b1;
                    grant_d      = sel;
                    case (sel)
                        GrClear: begin
                            seg_d       = ClearSeg;
                            burst_cnt_d = '0;
                        end
                        GrReq0: begin
                            seg_d       = req0_seg_in;
                            ready0_d    = 1'b1;
                            burst_cnt_d = (rr_q == 1'b0) ? burst_inc : BurstW'(1);
                            rr_d        = 1'b0;
                        end
                        GrReq1: begin
                            seg_d       = req1_seg_in;
                            ready1_d    = 1'b1;
                            burst_cnt_d = (rr_q == 1'b1) ? burst_inc : BurstW'(1);
                            rr_d        = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            StIssue: begin
                state_d   = StWaitBusy;
                tmo_cnt_d = '0;
            end
            StWaitBusy: begin
                if (disp_busy_in) begin
                    state_d = StWaitDone;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!disp_busy_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= StIdle;
            clear_pending_q <= 1'b0;
            rr_q            <= 1'b0;
            burst_cnt_q     <= '0;
            tmo_cnt_q       <= '0;
            disp_valid_q    <= 1'b0;
            ready0_q        <= 1'b0;
            ready1_q        <= 1'b0;
            seg_q           <= '0;
            grant_q         <= GrNone;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            rr_q            <= rr_d;
            burst_cnt_q     <= burst_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            disp_valid_q    <= disp_valid_d;
            ready0_q        <= ready0_d;
            ready1_q        <= ready1_d;
            seg_q           <= seg_d;
            grant_q         <= grant_d;
        end
    end

    assign disp_valid_out = disp_valid_q;
    assign disp_seg_out   = seg_q;
    assign grant_out      = grant_q;
    assign req0_ready_out = ready0_q;
    assign req1_ready_out = ready1_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized bench for draw_arbiter: requesters, clear pulses, a display busy model and resets,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_draw_arbiter;

    localparam int unsigned SEG_W  = 37;
    localparam int unsigned BURST  = 2;
    localparam int unsigned TMO    = 16;
    localparam int unsigned NCYC   = 4000;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             req0_valid_in, req1_valid_in;
    logic [SEG_W-1:0] req0_seg_in, req1_seg_in;
    logic             req0_ready_out, req1_ready_out;
    logic             clear_req_in;
    logic             disp_busy_in;
    logic             disp_valid_out;
    logic [SEG_W-1:0] disp_seg_out;
    logic [1:0]       grant_out;

    always #5 clk_in = ~clk_in;

    draw_arbiter #(
        .BURST        (BURST),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req0_valid_in  (req0_valid_in),
        .req0_seg_in    (req0_seg_in),
        .req0_ready_out (req0_ready_out),
        .req1_valid_in  (req1_valid_in),
        .req1_seg_in    (req1_seg_in),
        .req1_ready_out (req1_ready_out),
        .clear_req_in   (clear_req_in),
        .disp_busy_in   (disp_busy_in),
        .disp_valid_out (disp_valid_out),
        .disp_seg_out   (disp_seg_out),
        .grant_out      (grant_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Requester stimulus
    logic             v [2];
    logic [SEG_W-1:0] s [2];
    logic             rdy_seen [2];

    assign req0_valid_in = v[0];
    assign req1_valid_in = v[1];
    assign req0_seg_in   = s[0];
    assign req1_seg_in   = s[1];

    // Reference model state: outstanding command, its strobe cycle, busy-seen flag
    bit               m_out, m_rose, m_pend, m_last;
    int               m_s, m_run;
    bit               e_valid, e_r0, e_r1;
    logic [1:0]       e_grant;
    logic [SEG_W-1:0] e_seg;
    logic [SEG_W-1:0] clear_seg;

    int b_start, b_end;
    int n_strobe, n_clear;

    initial begin
        clear_seg = {8'd0, 8'd239, 9'd0, 9'd319, 3'd0};
        rst_n_in = 1'b1;
        v[0] = 1'b0; v[1] = 1'b0; s[0] = '0; s[1] = '0;
        rdy_seen[0] = 1'b0; rdy_seen[1] = 1'b0;
        clear_req_in = 1'b0; disp_busy_in = 1'b0;
        m_out = 0; m_rose = 0; m_pend = 0; m_last = 0; m_s = 0; m_run = 0;
        e_valid = 0; e_r0 = 0; e_r1 = 0; e_grant = '0; e_seg = '0;
        b_start = -1; b_end = -2; n_strobe = 0; n_clear = 0;

        #1 rst_n_in = 1'b0;
        #1;
        check_val("reset_valid", {63'd0, disp_valid_out}, 64'd0);
        check_val("reset_ready0", {63'd0, req0_ready_out}, 64'd0);
        check_val("reset_ready1", {63'd0, req1_ready_out}, 64'd0);
        check_val("reset_grant", {62'd0, grant_out}, 64'd0);
        check_val("reset_seg", {27'd0, disp_seg_out}, 64'd0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk_in);
            #1;
            rst_n_in     = !((cyc < 2) || ((cyc % 700) >= 697));
            disp_busy_in = (cyc >= b_start) && (cyc <= b_end);
            clear_req_in = ($urandom_range(0, 99) < 3);
            for (int i = 0; i < 2; i++) begin
                if (rdy_seen[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    s[i] = SEG_W'({$urandom(), $urandom()});
                end else if (!v[i]) begin
                    if ($urandom_range(0, 99) < 35) begin
                        v[i] = 1'b1;
                        s[i] = SEG_W'({$urandom(), $urandom()});
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    v[i] = 1'b0;
                end
            end

            @(negedge clk_in);
            if (!rst_n_in) begin
                e_valid = 0; e_r0 = 0; e_r1 = 0; e_grant = '0; e_seg = '0;
            end
            check_val("disp_valid", {63'd0, disp_valid_out}, {63'd0, e_valid});
            check_val("ready0", {63'd0, req0_ready_out}, {63'd0, e_r0});
            check_val("ready1", {63'd0, req1_ready_out}, {63'd0, e_r1});
            check_val("grant", {62'd0, grant_out}, {62'd0, e_grant});
            check_val("disp_seg", {27'd0, disp_seg_out}, {27'd0, e_seg});

            rdy_seen[0] = req0_ready_out;
            rdy_seen[1] = req1_ready_out;

            // Display model: reacts to strobes with a random busy pulse, sometimes none or late
            if (!rst_n_in) begin
                b_start = -1; b_end = -2;
            end else if (disp_valid_out) begin
                int r, d;
                n_strobe++;
                if (grant_out == 2'b11) n_clear++;
                r = int'($urandom_range(0, 99));
                if (r < 10) begin
                    b_start = -1; b_end = -2;
                end else begin
                    d = (r < 25) ? int'($urandom_range(14, 18)) : int'($urandom_range(1, 4));
                    b_start = cyc + d;
                    b_end   = b_start + int'($urandom_range(1, 5)) - 1;
                end
            end

            // Reference model step: predicts outputs for the next cycle
            if (!rst_n_in) begin
                m_out = 0; m_pend = 0; m_last = 0; m_run = 0;
                e_valid = 0; e_r0 = 0; e_r1 = 0; e_grant = '0; e_seg = '0;
            end else begin
                int pick;
                pick = 0;
                e_valid = 0; e_r0 = 0; e_r1 = 0;
                if (m_out) begin
                    if (cyc != m_s) begin
                        if (!m_rose) begin
                            if (disp_busy_in) m_rose = 1;
                            else if (cyc - m_s == int'(TMO)) m_out = 0;
                        end else if (!disp_busy_in) begin
                            m_out = 0;
                        end
                    end
                end else begin
                    if (m_pend) pick = 3;
                    else if (v[0] && v[1]) pick = ((m_run < int'(BURST)) ? int'(m_last)
                                                                       : int'(!m_last)) + 1;
                    else if (v[0]) pick = 1;
                    else if (v[1]) pick = 2;

                    if (pick == 3) begin
                        e_seg = clear_seg;
                        m_run = 0;
                    end else if (pick != 0) begin
                        bit o;
                        o = (pick == 2);
                        m_run  = (o == m_last) ? m_run + 1 : 1;
                        m_last = o;
                        e_seg  = s[o];
                        e_r0   = !o;
                        e_r1   = o;
                    end
                    if (pick != 0) begin
                        e_valid = 1;
                        e_grant = 2'(pick);
                        m_out   = 1;
                        m_s     = cyc + 1;
                        m_rose  = 0;
                    end
                end
                m_pend = (m_pend && (pick != 3)) || clear_req_in;
            end
        end

        check_val("strobes_seen", {63'd0, n_strobe > 100}, 64'd1);
        check_val("clears_seen", {63'd0, n_clear > 5}, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
